// File: rtl/mips_join.sv
// mips_join: single-cycle MIPS subset core (ADD/SUB/AND/OR/SLT/SLL, ADDI,
// LW, SW, BEQ, J). Fetch, decode, register file, ALU and data memory all
// resolve within one CLK period; PC, register write, memory write and
// SW_TEST commit together on the rising edge.
module mips_join (
    input  logic        CLK,
    input  logic        RST,
    output logic [31:0] TEST,
    output logic [31:0] SW_TEST
);

    // Opcode / function codes of the supported subset
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL   = 6'h00;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    // Architectural state
    logic [31:0] pc_q, pc_d;
    logic [31:0] sw_test_q, sw_test_d;
    logic [31:0] regs_q [32];
    logic [31:0] dmem_q [256];

    // Instruction ROM. The core never writes it; its image (ins.hex) is
    // placed by the platform memory-initialisation flow / simulation harness.
    logic [31:0] rom_mem [256];

    // Instruction fields
    logic [31:0] instr;
    logic [5:0]  op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [5:0]  funct;
    logic [15:0] imm;
    logic [25:0] jaddr;

    // Datapath signals
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic [31:0] ed32;
    logic [31:0] pc_plus4;
    logic [31:0] branch_target;
    logic [31:0] jump_target;
    logic [31:0] alu_res;
    logic [31:0] wb_data;
    logic [4:0]  wb_addr;
    logic        reg_we;
    logic        mem_we;
    logic        is_load;
    logic        is_branch;
    logic        is_jump;
    logic        branch_taken;

    // Fetch and field split
    always_comb begin
        instr = rom_mem[pc_q[9:2]];
        op    = instr[31:26];
        rs    = instr[25:21];
        rt    = instr[20:16];
        rd    = instr[15:11];
        shamt = instr[10:6];
        funct = instr[5:0];
        imm   = instr[15:0];
        jaddr = instr[25:0];
    end

    // Asynchronous register reads; $0 is hard-wired to zero
    always_comb begin
        rs_val = (rs == 5'd0) ? 32'h0000_0000 : regs_q[rs];
        rt_val = (rt == 5'd0) ? 32'h0000_0000 : regs_q[rt];
        ed32   = {{16{imm[15]}}, imm};
    end

    // Decode and ALU: unknown op/funct falls through as a NOP with result 0
    always_comb begin
        alu_res   = 32'h0000_0000;
        reg_we    = 1'b0;
        mem_we    = 1'b0;
        is_load   = 1'b0;
        is_branch = 1'b0;
        is_jump   = 1'b0;
        wb_addr   = 5'd0;
        case (op)
            OP_RTYPE: begin
                wb_addr = rd;
                reg_we  = 1'b1;
                case (funct)
                    FN_ADD:  alu_res = rs_val + rt_val;
                    FN_SUB:  alu_res = rs_val - rt_val;
                    FN_AND:  alu_res = rs_val & rt_val;
                    FN_OR:   alu_res = rs_val | rt_val;
                    FN_SLT:  alu_res = ($signed(rs_val) < $signed(rt_val)) ? 32'd1 : 32'd0;
                    FN_SLL:  alu_res = rt_val << shamt;
                    default: begin
                        alu_res = 32'h0000_0000;
                        reg_we  = 1'b0;
                    end
                endcase
            end
            OP_ADDI: begin
                alu_res = rs_val + ed32;
                wb_addr = rt;
                reg_we  = 1'b1;
            end
            OP_LW: begin
                alu_res = rs_val + ed32;
                wb_addr = rt;
                reg_we  = 1'b1;
                is_load = 1'b1;
            end
            OP_SW: begin
                alu_res = rs_val + ed32;
                mem_we  = 1'b1;
            end
            OP_BEQ: begin
                alu_res   = rs_val - rt_val;
                is_branch = 1'b1;
            end
            OP_J: begin
                is_jump = 1'b1;
            end
            default: begin
                alu_res = 32'h0000_0000;
            end
        endcase
    end

    // Write-back source: loaded word for LW, ALU result otherwise
    always_comb begin
        wb_data = is_load ? dmem_q[alu_res[9:2]] : alu_res;
    end

    // Next-PC selection (branch / jump / sequential)
    always_comb begin
        pc_plus4      = pc_q + 32'd4;
        branch_target = pc_plus4 + (ed32 << 2);
        jump_target   = {pc_plus4[31:28], jaddr, 2'b00};
        branch_taken  = is_branch && (alu_res == 32'h0000_0000);
        if (branch_taken) begin
            pc_d = branch_target;
        end else if (is_jump) begin
            pc_d = jump_target;
        end else begin
            pc_d = pc_plus4;
        end
        if (RST) begin
            pc_d = 32'h0000_0000;
        end
    end

    // SW observation register: captures the stored word, holds otherwise
    always_comb begin
        sw_test_d = sw_test_q;
        if (RST) begin
            sw_test_d = 32'h0000_0000;
        end else if (mem_we) begin
            sw_test_d = rt_val;
        end
    end

    // Observation outputs; TEST is forced low during reset
    always_comb begin
        TEST    = RST ? 32'h0000_0000 : alu_res;
        SW_TEST = sw_test_q;
    end

    // PC and SW_TEST commit
    always_ff @(posedge CLK) begin
        pc_q      <= pc_d;
        sw_test_q <= sw_test_d;
    end

    // Register file: cleared by reset, $0 writes discarded
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= 32'h0000_0000;
            end
        end else if (reg_we && (wb_addr != 5'd0)) begin
            regs_q[wb_addr] <= wb_data;
        end
    end

    // Data RAM: not cleared by reset; store suppressed while in reset
    always_ff @(posedge CLK) begin
        if (!RST && mem_we) begin
            dmem_q[alu_res[9:2]] <= rt_val;
        end
    end

endmodule

// File: tb/tb_mips_join.sv
// Directed bench for mips_join: loads a hand-assembled program into the
// instruction ROM, steps it one instruction per clock and compares TEST,
// SW_TEST and the PC against hand-computed values.
module tb_mips_join;

    logic        CLK;
    logic        RST;
    logic [31:0] TEST;
    logic [31:0] SW_TEST;

    int tests_run;
    int tests_failed;

    mips_join dut (
        .CLK     (CLK),
        .RST     (RST),
        .TEST    (TEST),
        .SW_TEST (SW_TEST)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $display("FAIL %s: observed=%h expected=%h", tag, obs, exp);
            $error("%s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Check TEST for the instruction at the current PC, then check the PC
    // reached after the next rising edge.
    task automatic exec(input string tag, input logic [31:0] exp_test, input logic [31:0] exp_pc);
        #1;
        chk({tag, "_test"}, TEST, exp_test);
        @(negedge CLK);
        chk({tag, "_pc"}, dut.pc_q, exp_pc);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        RST          = 1'b1;

        // Program A
        for (int i = 0; i < 256; i++) dut.rom_mem[i] = 32'h0000_0000;
        dut.rom_mem[0]  = 32'h200A0005; // 0x00 ADDI $10,$0,5
        dut.rom_mem[1]  = 32'h200B0007; // 0x04 ADDI $11,$0,7
        dut.rom_mem[2]  = 32'h014B4820; // 0x08 ADD  $9,$10,$11
        dut.rom_mem[3]  = 32'h200B0005; // 0x0C ADDI $11,$0,5
        dut.rom_mem[4]  = 32'h114B0007; // 0x10 BEQ  $10,$11,7
        dut.rom_mem[5]  = 32'h200F0063; // 0x14 ADDI $15,$0,99 (skipped)
        dut.rom_mem[8]  = 32'h0800003A; // 0x20 J 58
        dut.rom_mem[12] = 32'h21340000; // 0x30 ADDI $20,$9,0
        dut.rom_mem[13] = 32'h08000008; // 0x34 J 8
        dut.rom_mem[58] = 32'h20000009; // 0xE8 ADDI $0,$0,9
        dut.rom_mem[59] = 32'h0000A820; // 0xEC ADD  $21,$0,$0
        dut.rom_mem[60] = 32'h200AFFFD; // 0xF0 ADDI $10,$0,-3
        dut.rom_mem[61] = 32'h200B0002; // 0xF4 ADDI $11,$0,2
        dut.rom_mem[62] = 32'h014B482A; // 0xF8 SLT  $9,$10,$11
        dut.rom_mem[63] = 32'h016A482A; // 0xFC SLT  $9,$11,$10
        dut.rom_mem[64] = 32'h200A0008; // 0x100 ADDI $10,$0,8
        dut.rom_mem[65] = 32'h200BDEAE; // 0x104 ADDI $11,$0,0xDEAE
        dut.rom_mem[66] = 32'h000B5C00; // 0x108 SLL  $11,$11,16
        dut.rom_mem[67] = 32'h216BBEEF; // 0x10C ADDI $11,$11,0xBEEF
        dut.rom_mem[68] = 32'hAD4B0004; // 0x110 SW   $11,4($10)
        dut.rom_mem[69] = 32'h8D4C0004; // 0x114 LW   $12,4($10)
        dut.rom_mem[70] = 32'h218D0000; // 0x118 ADDI $13,$12,0
        dut.rom_mem[71] = 32'h014B7022; // 0x11C SUB  $14,$10,$11
        dut.rom_mem[72] = 32'h016E7824; // 0x120 AND  $15,$11,$14
        dut.rom_mem[73] = 32'h016E8025; // 0x124 OR   $16,$11,$14
        dut.rom_mem[74] = 32'hFC000000; // 0x128 unknown opcode
        dut.rom_mem[75] = 32'h0000503F; // 0x12C unknown funct, rd=$10
        dut.rom_mem[76] = 32'h21510000; // 0x130 ADDI $17,$10,0
        dut.rom_mem[77] = 32'hAC0B0000; // 0x134 SW   $11,0($0)

        // Reset held for two edges
        @(negedge CLK);
        chk("rst1_pc", dut.pc_q, 32'h0);
        chk("rst1_test", TEST, 32'h0);
        chk("rst1_swtest", SW_TEST, 32'h0);
        @(negedge CLK);
        chk("rst2_pc", dut.pc_q, 32'h0);
        chk("rst2_test", TEST, 32'h0);
        RST = 1'b0;

        exec("addi10",     32'd5,         32'h04);
        exec("addi11",     32'd7,         32'h08);
        exec("add",        32'd12,        32'h0C);
        exec("addi11b",    32'd5,         32'h10);
        exec("beq_taken",  32'd0,         32'h30);
        exec("add_rd",     32'd12,        32'h34);
        exec("j_back",     32'd0,         32'h20);
        exec("j58",        32'd0,         32'hE8);
        exec("addi_r0",    32'd9,         32'hEC);
        exec("r0_zero",    32'd0,         32'hF0);
        chk("r0_reg", dut.regs_q[0], 32'h0);
        exec("addi_neg3",  32'hFFFF_FFFD, 32'hF4);
        exec("addi2",      32'd2,         32'hF8);
        exec("slt_lt",     32'd1,         32'hFC);
        exec("slt_ge",     32'd0,         32'h100);
        exec("addi8",      32'd8,         32'h104);
        exec("addi_hi",    32'hFFFF_DEAE, 32'h108);
        exec("sll16",      32'hDEAE_0000, 32'h10C);
        exec("addi_lo",    32'hDEAD_BEEF, 32'h110);
        chk("swtest_pre", SW_TEST, 32'h0);
        exec("sw_ea",      32'd12,        32'h114);
        chk("swtest_post", SW_TEST, 32'hDEAD_BEEF);
        exec("lw_ea",      32'd12,        32'h118);
        chk("lw_reg", dut.regs_q[12], 32'hDEAD_BEEF);
        exec("lw_data",    32'hDEAD_BEEF, 32'h11C);
        exec("sub",        32'h2152_4119, 32'h120);
        exec("and",        32'h0000_0009, 32'h124);
        exec("or",         32'hFFFF_FFFF, 32'h128);
        chk("swtest_hold", SW_TEST, 32'hDEAD_BEEF);
        exec("bad_op",     32'd0,         32'h12C);
        exec("bad_funct",  32'd0,         32'h130);
        exec("r10_kept",   32'd8,         32'h134);

        // Mid-program reset aborts the SW at 0x134
        RST = 1'b1;
        #1;
        chk("midrst_test", TEST, 32'h0);
        @(negedge CLK);
        chk("midrst_pc", dut.pc_q, 32'h0);
        chk("midrst_swtest", SW_TEST, 32'h0);
        chk("midrst_r11", dut.regs_q[11], 32'h0);

        // Program B: BEQ not taken at 0x10, data RAM survives reset
        dut.rom_mem[0] = 32'h200A0001; // ADDI $10,$0,1
        dut.rom_mem[1] = 32'h200B0002; // ADDI $11,$0,2
        dut.rom_mem[2] = 32'h0000_0000;
        dut.rom_mem[3] = 32'h0000_0000;
        dut.rom_mem[4] = 32'h114B0007; // BEQ $10,$11,7
        dut.rom_mem[5] = 32'h8C0C000C; // LW  $12,12($0)
        dut.rom_mem[6] = 32'h218D0000; // ADDI $13,$12,0
        @(negedge CLK);
        RST = 1'b0;

        exec("b_addi1",    32'd1,         32'h04);
        exec("b_addi2",    32'd2,         32'h08);
        exec("b_nop1",     32'd0,         32'h0C);
        exec("b_nop2",     32'd0,         32'h10);
        exec("beq_not",    32'hFFFF_FFFF, 32'h14);
        exec("lw_kept_ea", 32'd12,        32'h18);
        exec("lw_kept",    32'hDEAD_BEEF, 32'h1C);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
